// File: rtl/instr_buffer.sv
// Circular instruction queue between fetch/decode and dispatch: up to four
// entries in and four out per cycle, flushed by a taken jump, frozen on halt.
module instr_buffer #(
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter int ENTRY_W = 39
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_jump,
    input  logic [4*ENTRY_W-1:0] in_entry_flat,
    input  logic [2:0]           in_count,
    output logic [2:0]           num_fetch,
    output logic [4*ENTRY_W-1:0] out_entry_flat,
    output logic [3:0]           out_valid,
    output logic [2:0]           out_count,
    input  logic [2:0]           deq_count,
    output logic                 halted_out
);

    localparam int LANES = 4;
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               halted;

    logic [ENTRY_W-1:0] in_lane [LANES];
    logic [CNT_W-1:0]   free_slots;
    logic [2:0]         in_clamped;
    logic [2:0]         accept;
    logic [2:0]         enq;
    logic [2:0]         deq;
    logic               halt_hit;

    // Lane 0 occupies the most significant slice of the flat bus.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            in_lane[k] = in_entry_flat[(LANES-k)*ENTRY_W-1 -: ENTRY_W];
        end
    end

    // Free space is taken before this cycle's dequeue, so a full buffer
    // accepts nothing even while dispatch is draining it.
    always_comb begin
        free_slots = CNT_W'(DEPTH) - count;
        if (halted) begin
            num_fetch = 3'd0;
        end else if (free_slots >= CNT_W'(LANES)) begin
            num_fetch = 3'd4;
        end else begin
            num_fetch = free_slots[2:0];
        end
    end

    always_comb begin
        if (count >= CNT_W'(LANES)) begin
            out_count = 3'd4;
        end else begin
            out_count = count[2:0];
        end
    end

    always_comb begin
        in_clamped = (in_count > 3'd4) ? 3'd4 : in_count;
        accept     = (in_clamped < num_fetch) ? in_clamped : num_fetch;
    end

    // The first accepted halt truncates the group right after itself.
    // NOTE: always_comb uses blocking '=' so later loop iterations see the
    // halt_hit/enq values updated by earlier ones; '<=' here would break the scan.
    always_comb begin
        enq      = accept;
        halt_hit = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (!halt_hit && (3'(k) < accept) && in_lane[k][0]) begin
                halt_hit = 1'b1;
                enq      = 3'(k + 1);
            end
        end
    end

    always_comb begin
        deq = (deq_count < out_count) ? deq_count : out_count;
    end

    always_comb begin
        out_entry_flat = '0;
        out_valid      = 4'b0000;
        for (int k = 0; k < LANES; k++) begin
            out_entry_flat[(LANES-k)*ENTRY_W-1 -: ENTRY_W] = storage[PTR_W'(head + PTR_W'(k))];
            out_valid[LANES-1-k] = (3'(k) < out_count);
        end
    end

    assign halted_out = halted;

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else if (is_jump) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            head  <= head + PTR_W'(deq);
            tail  <= tail + PTR_W'(enq);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
            if (halt_hit) begin
                halted <= 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; count/out_valid gate every read,
    // and leaving it resetless lets the array map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (!rst && !is_jump) begin
            for (int k = 0; k < LANES; k++) begin
                if (3'(k) < enq) begin
                    storage[PTR_W'(tail + PTR_W'(k))] <= in_lane[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: a table of single-cycle vectors followed by
// hand-written fill, wrap-around, halt and flush sequences.
module tb_instr_buffer;

    localparam int EW = 39;
    localparam int NH = -1;  // no halt lane

    logic            clk = 1'b0;
    logic            rst;
    logic            is_jump;
    logic [4*EW-1:0] in_entry_flat;
    logic [2:0]      in_count;
    logic [2:0]      num_fetch;
    logic [4*EW-1:0] out_entry_flat;
    logic [3:0]      out_valid;
    logic [2:0]      out_count;
    logic [2:0]      deq_count;
    logic            halted_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_buffer #(.DEPTH(16), .PTR_W(4), .ENTRY_W(EW)) dut (
        .clk            (clk),
        .rst            (rst),
        .is_jump        (is_jump),
        .in_entry_flat  (in_entry_flat),
        .in_count       (in_count),
        .num_fetch      (num_fetch),
        .out_entry_flat (out_entry_flat),
        .out_valid      (out_valid),
        .out_count      (out_count),
        .deq_count      (deq_count),
        .halted_out     (halted_out)
    );

    typedef struct {
        logic       r;
        logic       j;
        logic [2:0] ic;
        logic [7:0] base;
        int         hl;
        logic [2:0] dq;
        logic [2:0] nf;
        logic [2:0] oc;
        logic [3:0] ov;
        logic [7:0] imm0;
        logic [7:0] imm3;
        logic       h;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [EW-1:0] mk(input logic [7:0] imm, input logic halt);
        return {imm[3:0], imm, 26'b0, halt};
    endfunction

    function automatic logic [EW-1:0] lane(input int k);
        return out_entry_flat[(4-k)*EW-1 -: EW];
    endfunction

    function automatic vec_t mkv(input logic r, input logic j, input logic [2:0] ic,
                                 input logic [7:0] base, input int hl, input logic [2:0] dq,
                                 input logic [2:0] nf, input logic [2:0] oc, input logic [3:0] ov,
                                 input logic [7:0] imm0, input logic [7:0] imm3, input logic h);
        vec_t v;
        v.r = r; v.j = j; v.ic = ic; v.base = base; v.hl = hl; v.dq = dq;
        v.nf = nf; v.oc = oc; v.ov = ov; v.imm0 = imm0; v.imm3 = imm3; v.h = h;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs after a falling edge, clock them in, sample at the next falling edge.
    task automatic drive(input logic r, input logic j, input logic [2:0] ic,
                         input logic [7:0] base, input int hl, input logic [2:0] dq);
        rst       = r;
        is_jump   = j;
        in_count  = ic;
        deq_count = dq;
        for (int k = 0; k < 4; k++) begin
            in_entry_flat[(4-k)*EW-1 -: EW] = mk(8'(int'(base) + k), k == hl);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [2:0] nf, input logic [2:0] oc,
                               input logic [3:0] ov, input logic h);
        check({tag, ".num_fetch"}, 32'(num_fetch), 32'(nf));
        check({tag, ".out_count"}, 32'(out_count), 32'(oc));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".halted"},    32'(halted_out), 32'(h));
    endtask

    task automatic check_imm(input string tag, input int k, input logic [7:0] exp);
        logic [EW-1:0] e;
        e = lane(k);
        check($sformatf("%s.lane%0d_imm", tag, k), 32'(e[34:27]), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; is_jump = 1'b0; in_count = '0; deq_count = '0; in_entry_flat = '0;

        //          r  j  ic  base hl  dq   nf  oc  ov       imm0 imm3 h
        vecs[0]  = mkv(1, 0, 0, 0,  NH, 0,  4,  0,  4'b0000, 0,   0,   0);
        vecs[1]  = mkv(0, 0, 0, 0,  NH, 0,  4,  0,  4'b0000, 0,   0,   0);
        vecs[2]  = mkv(0, 0, 0, 0,  NH, 0,  4,  0,  4'b0000, 0,   0,   0);
        vecs[3]  = mkv(0, 0, 0, 0,  NH, 0,  4,  0,  4'b0000, 0,   0,   0);
        vecs[4]  = mkv(0, 0, 4, 1,  NH, 0,  4,  4,  4'b1111, 1,   4,   0);
        vecs[5]  = mkv(0, 0, 4, 5,  NH, 0,  4,  4,  4'b1111, 1,   4,   0);
        vecs[6]  = mkv(0, 0, 0, 0,  NH, 2,  4,  4,  4'b1111, 3,   6,   0);
        vecs[7]  = mkv(0, 0, 7, 9,  NH, 0,  4,  4,  4'b1111, 3,   6,   0);
        vecs[8]  = mkv(0, 0, 3, 13, NH, 7,  4,  4,  4'b1111, 7,   10,  0);
        vecs[9]  = mkv(0, 0, 2, 20, 1,  1,  0,  4,  4'b1111, 8,   11,  1);
        vecs[10] = mkv(1, 0, 4, 30, NH, 3,  4,  0,  4'b0000, 0,   0,   0);

        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].r, vecs[i].j, vecs[i].ic, vecs[i].base, vecs[i].hl, vecs[i].dq);
            check_state($sformatf("v%0d", i), vecs[i].nf, vecs[i].oc, vecs[i].ov, vecs[i].h);
            if (vecs[i].oc != 3'd0) begin
                check_imm($sformatf("v%0d", i), 0, vecs[i].imm0);
                check($sformatf("v%0d.lane0_opcode", i), 32'(lane(0)[38:35]), 32'(vecs[i].imm0[3:0]));
            end
            if (vecs[i].oc == 3'd4) check_imm($sformatf("v%0d", i), 3, vecs[i].imm3);
        end

        // Fill to full, overflow drop, and no acceptance while a full buffer drains.
        drive(1, 0, 0, 0, NH, 0);
        drive(0, 0, 4, 0, NH, 0);
        drive(0, 0, 4, 4, NH, 0);
        drive(0, 0, 4, 8, NH, 0);
        check("fill12.num_fetch", 32'(num_fetch), 32'd4);
        drive(0, 0, 2, 12, NH, 0);
        check_state("fill14", 2, 4, 4'b1111, 0);
        drive(0, 0, 4, 14, NH, 0);
        check_state("fill16", 0, 4, 4'b1111, 0);
        check_imm("fill16", 0, 8'd0);
        drive(0, 0, 4, 20, NH, 3);
        check_state("full_drain", 3, 4, 4'b1111, 0);
        check_imm("full_drain", 0, 8'd3);
        drive(0, 0, 4, 20, NH, 0);
        check_state("refill", 0, 4, 4'b1111, 0);
        drive(0, 0, 0, 0, NH, 4);
        check_imm("drain1", 0, 8'd7);
        check("drain1.num_fetch", 32'(num_fetch), 32'd4);
        drive(0, 0, 0, 0, NH, 4);
        check_imm("drain2", 0, 8'd11);
        drive(0, 0, 0, 0, NH, 4);
        check_imm("drain3", 0, 8'd15);
        check_imm("drain3", 3, 8'd22);
        drive(0, 0, 0, 0, NH, 4);
        check_state("drain4", 4, 0, 4'b0000, 0);

        // Steady enqueue 3 / dequeue 3 at count 6 across two pointer wraps.
        drive(1, 0, 0, 0, NH, 0);
        drive(0, 0, 4, 0, NH, 0);
        drive(0, 0, 2, 4, NH, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 3, 8'(6 + 3*i), NH, 3);
            check_state($sformatf("wrap%0d", i), 4, 4, 4'b1111, 0);
            for (int k = 0; k < 4; k++) begin
                check_imm($sformatf("wrap%0d", i), k, 8'(3*(i+1) + k));
            end
        end

        // Halt truncation, freeze while draining, release on jump.
        drive(1, 0, 0, 0, NH, 0);
        drive(0, 0, 4, 0, NH, 0);
        drive(0, 0, 4, 10, 1, 0);
        check_state("halt_in", 0, 4, 4'b1111, 1);
        drive(0, 0, 4, 60, NH, 4);
        check_state("halt_drain", 0, 2, 4'b1100, 1);
        check_imm("halt_drain", 0, 8'd10);
        check_imm("halt_drain", 1, 8'd11);
        check("halt_drain.lane1_is_halt", 32'(lane(1)[0]), 32'd1);
        drive(0, 0, 0, 0, NH, 4);
        check_state("halt_empty", 0, 0, 4'b0000, 1);
        drive(0, 1, 4, 70, NH, 0);
        check_state("halt_jump", 4, 0, 4'b0000, 0);
        drive(0, 0, 2, 40, 3, 0);
        check_state("halt_beyond_count", 4, 2, 4'b1100, 0);
        check_imm("halt_beyond_count", 0, 8'd40);
        drive(0, 0, 3, 50, 0, 0);
        check_state("halt_lane0", 0, 3, 4'b1110, 1);
        check_imm("halt_lane0", 2, 8'd50);

        // Flush with simultaneous enqueue/dequeue, then reset mid-fill.
        drive(1, 0, 0, 0, NH, 0);
        drive(0, 0, 4, 0, NH, 0);
        drive(0, 0, 4, 4, NH, 0);
        check_state("pre_flush", 4, 4, 4'b1111, 0);
        drive(0, 1, 4, 100, NH, 2);
        check_state("flush", 4, 0, 4'b0000, 0);
        drive(0, 0, 0, 0, NH, 0);
        check_state("flush_idle", 4, 0, 4'b0000, 0);
        drive(0, 0, 4, 110, NH, 0);
        check_imm("post_flush", 0, 8'd110);
        drive(0, 0, 1, 114, NH, 0);
        check_state("fill5", 4, 4, 4'b1111, 0);
        check_imm("fill5", 0, 8'd110);
        drive(1, 0, 4, 120, NH, 3);
        check_state("mid_reset", 4, 0, 4'b0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
